// File: rtl/taxi_sfp_link_ctrl_pkg.sv
// Shared types and constants for the SFP+ link bring-up controller.
package taxi_sfp_link_ctrl_pkg;

  localparam int RETRY_CNT_W = 8;

  typedef enum logic [2:0] {
    ABSENT,
    RESET,
    WAIT_TX,
    WAIT_RX,
    UP,
    FAULT
  } sfp_link_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/taxi_sfp_port_fsm.sv
// One SFP port: pin synchronizers and debouncers, state timer, bring-up FSM,
// retry counter and registered output decode.
module taxi_sfp_port_fsm
  import taxi_sfp_link_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RST_CYCLES      = 64,
  parameter int LOCK_TIMEOUT    = 2**20,
  parameter int FAULT_HOLD      = 2**16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   npres_i,
  input  logic                   tx_fault_i,
  input  logic                   los_i,
  input  logic                   tx_rst_done_i,
  input  logic                   rx_rst_done_i,
  input  logic                   block_lock_i,
  input  logic                   blink_i,
  output logic                   xcvr_tx_rst_o,
  output logic                   xcvr_rx_rst_o,
  output logic                   sfp_tx_disable_o,
  output logic                   link_up_o,
  output logic                   sfp_led_o,
  output logic [RETRY_CNT_W-1:0] retry_cnt_o
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW  = $clog2(max3(LOCK_TIMEOUT, FAULT_HOLD, RST_CYCLES)) + 1;
  // Pin vector order {los, tx_fault, npres}; idle values assume no module.
  localparam logic [2:0] PIN_RST = 3'b101;

  logic [2:0]          pin_a, sync1_q, sync2_q, filt_q;
  logic [2:0][DBW-1:0] dbc_q;

  assign pin_a = {los_i, tx_fault_i, npres_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= PIN_RST;
      sync2_q <= PIN_RST;
      filt_q  <= PIN_RST;
      dbc_q   <= '0;
    end else begin
      sync1_q <= pin_a;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (dbc_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            filt_q[i] <= sync2_q[i];
            dbc_q[i]  <= '0;
          end else begin
            dbc_q[i]  <= dbc_q[i] + 1'b1;
          end
        end else begin
          dbc_q[i] <= '0;
        end
      end
    end
  end

  sfp_link_state_t       state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [RETRY_CNT_W-1:0] retry_q;
  logic                  retry_inc, lock_to;
  logic                  npres_f, fault_f, los_f;

  assign {los_f, fault_f, npres_f} = filt_q;
  assign lock_to = timer_q >= TW'(LOCK_TIMEOUT - 1);

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    if (npres_f) begin
      state_d = ABSENT;
    end else if (fault_f && state_q != ABSENT && state_q != FAULT) begin
      state_d   = FAULT;
      retry_inc = 1'b1;
    end else begin
      unique case (state_q)
        ABSENT:  state_d = RESET;
        RESET:   if (timer_q >= TW'(RST_CYCLES - 1)) state_d = WAIT_TX;
        WAIT_TX: begin
          if (tx_rst_done_i) state_d = WAIT_RX;
          else if (lock_to) begin state_d = RESET; retry_inc = 1'b1; end
        end
        WAIT_RX: begin
          if (rx_rst_done_i && block_lock_i && !los_f) state_d = UP;
          else if (lock_to) begin state_d = RESET; retry_inc = 1'b1; end
        end
        UP:      if (!block_lock_i || los_f) state_d = WAIT_RX;
        FAULT:   if (timer_q >= TW'(FAULT_HOLD - 1)) state_d = RESET;
        default: state_d = ABSENT;
      endcase
    end
    // Saturate so idle states (ABSENT, UP) never wrap into a false terminal count.
    timer_d = (state_d != state_q) ? '0 : ((&timer_q) ? timer_q : timer_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ABSENT;
      timer_q          <= '0;
      retry_q          <= '0;
      xcvr_tx_rst_o    <= 1'b1;
      xcvr_rx_rst_o    <= 1'b1;
      sfp_tx_disable_o <= 1'b1;
      link_up_o        <= 1'b0;
      sfp_led_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (retry_inc && retry_q != '1) retry_q <= retry_q + 1'b1;
      xcvr_tx_rst_o    <= state_q inside {ABSENT, RESET, FAULT};
      xcvr_rx_rst_o    <= state_q inside {ABSENT, RESET, FAULT, WAIT_TX};
      sfp_tx_disable_o <= state_q inside {ABSENT, FAULT};
      link_up_o        <= state_q == UP;
      sfp_led_o        <= (state_q == UP) | (blink_i & (state_q inside {RESET, WAIT_TX, WAIT_RX}));
    end
  end

  assign retry_cnt_o = retry_q;

endmodule

// File: rtl/taxi_sfp_link_ctrl.sv
// SFP+ link bring-up controller: shared LED blink timebase plus one
// independent port FSM per SFP cage.
module taxi_sfp_link_ctrl
  import taxi_sfp_link_ctrl_pkg::*;
#(
  parameter int PORTS           = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RST_CYCLES      = 64,
  parameter int LOCK_TIMEOUT    = 2**20,
  parameter int FAULT_HOLD      = 2**16,
  parameter int BLINK_CYCLES    = 2**23
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORTS-1:0]                   sfp_npres,
  input  logic [PORTS-1:0]                   sfp_tx_fault,
  input  logic [PORTS-1:0]                   sfp_los,
  input  logic [PORTS-1:0]                   xcvr_tx_rst_done,
  input  logic [PORTS-1:0]                   xcvr_rx_rst_done,
  input  logic [PORTS-1:0]                   rx_block_lock,
  output logic [PORTS-1:0]                   xcvr_tx_rst,
  output logic [PORTS-1:0]                   xcvr_rx_rst,
  output logic [PORTS-1:0]                   sfp_tx_disable,
  output logic [PORTS-1:0]                   link_up,
  output logic [PORTS-1:0]                   sfp_led,
  output logic [PORTS-1:0][RETRY_CNT_W-1:0]  retry_cnt
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    taxi_sfp_port_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_CYCLES      (RST_CYCLES),
      .LOCK_TIMEOUT    (LOCK_TIMEOUT),
      .FAULT_HOLD      (FAULT_HOLD)
    ) u_port (
      .clk              (clk),
      .rst_n            (rst_n),
      .npres_i          (sfp_npres[p]),
      .tx_fault_i       (sfp_tx_fault[p]),
      .los_i            (sfp_los[p]),
      .tx_rst_done_i    (xcvr_tx_rst_done[p]),
      .rx_rst_done_i    (xcvr_rx_rst_done[p]),
      .block_lock_i     (rx_block_lock[p]),
      .blink_i          (blink_q),
      .xcvr_tx_rst_o    (xcvr_tx_rst[p]),
      .xcvr_rx_rst_o    (xcvr_rx_rst[p]),
      .sfp_tx_disable_o (sfp_tx_disable[p]),
      .link_up_o        (link_up[p]),
      .sfp_led_o        (sfp_led[p]),
      .retry_cnt_o      (retry_cnt[p])
    );
  end

endmodule

// File: tb/tb_taxi_sfp_link_ctrl.sv
// Directed bench for taxi_sfp_link_ctrl with short timing parameters.
module tb_taxi_sfp_link_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       npres, fault, los, txd, rxd, lock;
  logic [1:0]       tx_rst, rx_rst, dis, link, led;
  logic [1:0][7:0]  retry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  taxi_sfp_link_ctrl #(
    .PORTS(2), .DEBOUNCE_CYCLES(4), .RST_CYCLES(8),
    .LOCK_TIMEOUT(64), .FAULT_HOLD(16), .BLINK_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sfp_npres(npres), .sfp_tx_fault(fault), .sfp_los(los),
    .xcvr_tx_rst_done(txd), .xcvr_rx_rst_done(rxd), .rx_block_lock(lock),
    .xcvr_tx_rst(tx_rst), .xcvr_rx_rst(rx_rst), .sfp_tx_disable(dis),
    .link_up(link), .sfp_led(led), .retry_cnt(retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txrst"}, tx_rst, 2'b11);
    chk({tag, "_rxrst"}, rx_rst, 2'b11);
    chk({tag, "_dis"},   dis,    2'b11);
    chk({tag, "_link"},  link,   2'b00);
    chk({tag, "_led"},   led,    2'b00);
    chk({tag, "_retry"}, retry,  16'h0);
  endtask

  initial begin
    int n, cnt, last, toggles;
    logic prev;

    rst_n = 1'b0; npres = 2'b11; fault = 2'b00; los = 2'b11;
    txd = 2'b00; rxd = 2'b00; lock = 2'b00;
    ticks(3);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    ticks(100);
    chk_reset_vals("absent_100");

    // Insert port 0: pin -> output latency 2 + 4 + 1 + 1 edges.
    los[0] = 1'b0; npres[0] = 1'b0;
    ticks(7);
    chk("ins_pre_dis", dis[0], 1'b1);
    tick();
    chk("ins_dis", dis[0], 1'b0);
    chk("ins_txrst", tx_rst[0], 1'b1);
    ticks(7);
    chk("rst_hold_pre", tx_rst[0], 1'b1);
    tick();
    chk("rst_hold_done", tx_rst[0], 1'b0);
    chk("wait_tx_rxrst", rx_rst[0], 1'b1);
    ticks(4);
    txd[0] = 1'b1;
    tick();
    chk("wait_rx_pre", rx_rst[0], 1'b1);
    tick();
    chk("wait_rx_rxrst", rx_rst[0], 1'b0);
    chk("wait_rx_txrst", tx_rst[0], 1'b0);
    rxd[0] = 1'b1; lock[0] = 1'b1;
    tick();
    chk("up_pre", link[0], 1'b0);
    tick();
    chk("up_link", link[0], 1'b1);
    chk("up_led", led[0], 1'b1);
    chk("up_retry", retry[0], 8'd0);
    chk("p1_absent_dis", dis[1], 1'b1);
    chk("p1_absent_link", link[1], 1'b0);
    cnt = 0;
    repeat (20) begin tick(); if (!led[0]) cnt++; end
    chk("led_solid_lows", cnt, 0);

    // One-cycle block lock drop: back to WAIT_RX and straight up again.
    lock[0] = 1'b0;
    tick();
    lock[0] = 1'b1;
    chk("relock_t1_link", link[0], 1'b1);
    tick();
    chk("relock_t2_link", link[0], 1'b0);
    chk("relock_t2_rxrst", rx_rst[0], 1'b0);
    tick();
    chk("relock_t3_link", link[0], 1'b1);
    chk("relock_retry", retry[0], 8'd0);

    // 10-cycle TX fault while UP.
    fault[0] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (t == 10) fault[0] = 1'b0;
      if (t == 7) begin
        chk("fault_retry", retry[0], 8'd1);
        chk("fault_t7_dis", dis[0], 1'b0);
      end
      if (t == 8) begin
        chk("fault_t8_dis", dis[0], 1'b1);
        chk("fault_t8_link", link[0], 1'b0);
      end
      if (t == 23) chk("fault_t23_dis", dis[0], 1'b1);
      if (t == 24) begin
        chk("fault_t24_dis", dis[0], 1'b0);
        chk("fault_t24_txrst", tx_rst[0], 1'b1);
      end
    end
    n = 0;
    while (!link[0] && n < 60) begin tick(); n++; end
    chk("reup_link", link[0], 1'b1);
    chk("reup_retry", retry[0], 8'd1);

    // 3-cycle fault glitch is filtered.
    fault[0] = 1'b1;
    ticks(3);
    fault[0] = 1'b0;
    cnt = 0;
    repeat (20) begin tick(); if (!link[0]) cnt++; end
    chk("glitch_link_drops", cnt, 0);
    chk("glitch_retry", retry[0], 8'd1);

    // Port 1 inserted but TX reset never completes: repeated timeouts.
    npres[1] = 1'b0;
    n = 0;
    while (dis[1] && n < 20) begin tick(); n++; end
    chk("p1_ins_dis", dis[1], 1'b0);
    n = 0;
    while (tx_rst[1] && n < 20) begin tick(); n++; end
    chk("p1_rst_len", n, 8);
    n = 0; toggles = 0; last = 0; prev = led[1];
    while (!tx_rst[1] && n < 100) begin
      tick(); n++;
      if (led[1] !== prev) begin
        if (toggles > 0) chk("blink_half_period", n - last, 8);
        toggles++; last = n; prev = led[1];
      end
    end
    chk("p1_wait_tx_len1", n, 64);
    chk("p1_retry1", retry[1], 8'd1);
    chk("blink_toggles_ge6", (toggles >= 6) ? 1 : 0, 1);
    n = 0;
    while (tx_rst[1] && n < 20) begin tick(); n++; end
    chk("p1_rst_len2", n, 8);
    n = 0;
    while (!tx_rst[1] && n < 100) begin tick(); n++; end
    chk("p1_wait_tx_len2", n, 64);
    chk("p1_retry2", retry[1], 8'd2);
    chk("p0_still_up", link[0], 1'b1);

    // Port 0 in WAIT_RX: removal and fault together, removal wins.
    lock[0] = 1'b0;
    ticks(2);
    chk("p0_wait_rx_link", link[0], 1'b0);
    chk("p0_wait_rx_rxrst", rx_rst[0], 1'b0);
    npres[0] = 1'b1; fault[0] = 1'b1;
    ticks(8);
    chk("rm_txrst", tx_rst[0], 1'b1);
    chk("rm_dis", dis[0], 1'b1);
    chk("rm_retry_kept", retry[0], 8'd1);
    ticks(30);
    chk("rm_dis_held", dis[0], 1'b1);
    chk("rm_retry_held", retry[0], 8'd1);

    // Re-insert, bring up, then async reset mid-UP.
    npres[0] = 1'b0; fault[0] = 1'b0; lock[0] = 1'b1;
    n = 0;
    while (!link[0] && n < 60) begin tick(); n++; end
    chk("reins_link", link[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_sfp_link_ctrl.md
# taxi_sfp_link_ctrl

Per-port link bring-up controller for the SFP+ transceiver datapath. It sits between the board SFP status pins and the transceiver/PHY reset and status signals inside the core. It sequences transceiver TX/RX resets after module insertion and waits for lock with timeouts and retries. It also handles TX fault recovery, and drives the per-port SFP LEDs and `link_up` status.

## Interface
- `PORTS`, 2: number of SFP ports (1–4)
- `DEBOUNCE_CYCLES`, 1024: cycles a synchronized pin must be stable before it is accepted
- `RST_CYCLES`, 64: cycles TX/RX resets are held in state RESET
- `LOCK_TIMEOUT`, 2**20: cycles allowed in WAIT_TX or WAIT_RX before a retry
- `FAULT_HOLD`, 2**16: cycles TX is disabled after a TX fault
- `BLINK_CYCLES`, 2**23: LED half-period while bringing up
- `clk` input 1: controller clock, all logic in this domain
- `rst_n` input 1: asynchronous active-low reset; deassertion synchronous to `clk` upstream
- `sfp_npres[PORTS]` input 1: module absent, asynchronous pin
- `sfp_tx_fault[PORTS]` input 1: TX fault, asynchronous pin
- `sfp_los[PORTS]` input 1: loss of signal, asynchronous pin
- `xcvr_tx_rst_done[PORTS]` input 1: transceiver TX reset complete, already in `clk` domain
- `xcvr_rx_rst_done[PORTS]` input 1: transceiver RX reset complete, already in `clk` domain
- `rx_block_lock[PORTS]` input 1: PHY block lock, already in `clk` domain
- `xcvr_tx_rst[PORTS]` output 1: transceiver TX reset, active high
- `xcvr_rx_rst[PORTS]` output 1: transceiver RX reset, active high
- `sfp_tx_disable[PORTS]` output 1: SFP TX disable
- `link_up[PORTS]` output 1: port in state UP
- `sfp_led[PORTS]` output 1: status LED
- `retry_cnt[PORTS]` output 8: saturating count of timeouts plus faults

## Operation
- Pins: two-flop synchronizer, then debounce counter per pin. The filtered value updates only after `DEBOUNCE_CYCLES` consecutive equal samples. Filtered values reset to npres=1, fault=0, los=1.
- Per-port FSM states:
  - ABSENT: tx_rst=1, rx_rst=1, tx_disable=1. On filtered npres=0, go to RESET.
  - RESET: tx_rst=1, rx_rst=1, tx_disable=0. After `RST_CYCLES`, go to WAIT_TX.
  - WAIT_TX: tx_rst=0, rx_rst=1. On tx_rst_done, go to WAIT_RX.
  - WAIT_RX: tx_rst=0, rx_rst=0. On rx_rst_done && block_lock && !los, go to UP.
  - UP: link_up=1. On !block_lock or los, go to WAIT_RX with the timer cleared; RX is not reset.
  - FAULT: tx_rst=1, rx_rst=1, tx_disable=1. After `FAULT_HOLD`, go to RESET.
- One timer per port, cleared on every state change.
  - Timer reaching `LOCK_TIMEOUT` in WAIT_TX or WAIT_RX: go to RESET and increment retry_cnt.
  - Entry to FAULT also increments retry_cnt.
  - retry_cnt saturates at 255 and clears only on reset.
- Priority, evaluated each cycle from any state:
  1. Filtered npres=1: go to ABSENT; retry_cnt is kept.
  2. Filtered tx_fault=1 in any state other than ABSENT or FAULT: go to FAULT.
  3. Normal transitions.
- LED:
  - UP: on.
  - RESET, WAIT_TX, WAIT_RX: toggle from a shared free-running blink counter.
  - ABSENT, FAULT: off.

## Timing
- All outputs are registered and decoded from the state register. The outputs change in the cycle after the state register updates.
- Reset values: state ABSENT, xcvr_tx_rst=1, xcvr_rx_rst=1, sfp_tx_disable=1, link_up=0, sfp_led=0, retry_cnt=0, timers=0, blink phase=0.
- Latency from a pin change to the state change is 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles. The matching output changes 1 cycle later.
- Status inputs (rst_done, block_lock) are not debounced. The state changes 1 cycle after they are sampled.
- Timer width is $clog2(max(LOCK_TIMEOUT, FAULT_HOLD, RST_CYCLES))+1 bits. The compare is `>=`, so a terminal count never wraps.
- Ports are fully independent. Events on different ports in the same cycle are each handled in that cycle.
- When rst_n is asserted mid-sequence, all outputs return to their reset values immediately (asynchronous).

## Structure
- Package `taxi_sfp_link_ctrl_pkg`:
  - enum `sfp_link_state_t` with values ABSENT, RESET, WAIT_TX, WAIT_RX, UP, FAULT
  - constant `RETRY_CNT_W = 8`
- Sub-module `taxi_sfp_port_fsm`: one port's synchronizers, debouncers, timer, FSM and retry counter. Instantiated `PORTS` times in a generate loop.
- The top level holds only the shared blink counter and the generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, RST_CYCLES=8, LOCK_TIMEOUT=64, FAULT_HOLD=16, BLINK_CYCLES=8.
- Reset with npres=1 → every output at its reset value; state stays ABSENT for 100 cycles.
- Insert port0 (npres=0), assert tx_rst_done 5 cycles after tx_rst falls, then rx_rst_done, block_lock=1 and los=0 → the sequence ABSENT→RESET (8 cycles)→WAIT_TX→WAIT_RX→UP, link_up[0]=1, LED solid; port1 stays ABSENT.
- Never assert tx_rst_done → RESET re-entered after 64 cycles in WAIT_TX, retry_cnt=1, then 2 after the next timeout; the LED blinks with period 16.
- In UP, drop block_lock for 1 cycle → WAIT_RX with link_up=0 and rx_rst held at 0; on relock, UP again with no retry increment.
- In UP, assert tx_fault for 10 cycles → FAULT, tx_disable=1 for 16 cycles, then RESET; retry_cnt increments by 1. A 3-cycle fault glitch → no state change.
- Assert npres=1 while in WAIT_RX and at the same time assert tx_fault → ABSENT (removal wins); pulse rst_n low mid-UP → all outputs at reset values asynchronously.
